// File: rtl/frame_write_arbiter_pkg.sv
// Shared types and constants for the frame write arbiter slice.
package frame_write_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    DRAW  = 2'd1,
    DONE  = 2'd2
  } fw_phase_t;

  localparam int COORD_W   = 10;
  localparam int PIX_W     = 4;
  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;

endpackage

// File: rtl/frame_write_arbiter_rr_arbiter.sv
// Round-robin arbiter: the first requester after the last granted one wins.
// The pointer only moves when the caller reports an accepted grant.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_last;
  logic [PW-1:0] w_winner;

  // Scan from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant    = '0;
    w_winner = r_last;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(r_last) + k) % N]) begin
        grant                            = '0;
        grant[(int'(r_last) + k) % N]    = 1'b1;
        w_winner                         = PW'((int'(r_last) + k) % N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= PW'(N - 1);
    end else if (advance) begin
      r_last <= w_winner;
    end
  end

endmodule

// File: rtl/frame_write_arbiter.sv
// Sequences per-frame clear sweep, arbitrated draw and done/swap handshake onto the GPU write port.
// Clear sweep is built only when FRAME_WRITE_CLEAR_EN is defined.
module frame_write_arbiter
  import frame_write_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int H_RES   = DEF_H_RES,
  parameter int V_RES   = DEF_V_RES
) (
  input  logic                       gpu_clk_150,
  input  logic                       reset,
  input  logic                       gpu_start,
  input  logic [PIX_W-1:0]           clear_color,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*COORD_W-1:0] req_x,
  input  logic [NUM_REQ*COORD_W-1:0] req_y,
  input  logic [NUM_REQ*PIX_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_frame_done,
  output logic [COORD_W-1:0]         gpu_x,
  output logic [COORD_W-1:0]         gpu_y,
  output logic [PIX_W-1:0]           gpu_data,
  output logic                       gpu_we,
  output logic                       gpu_done,
  output logic [1:0]                 phase
);

  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] V_LIM = COORD_W'(V_RES);

`ifdef FRAME_WRITE_CLEAR_EN
  localparam fw_phase_t START_PHASE = CLEAR;
`else
  localparam fw_phase_t START_PHASE = DRAW;
`endif

  fw_phase_t            r_state;
  fw_phase_t            w_next;
  logic                 r_startQ;
  logic                 w_rise;
  logic [COORD_W-1:0]   r_gpuX;
  logic [COORD_W-1:0]   r_gpuY;
  logic [PIX_W-1:0]     r_gpuData;
  logic                 r_gpuWe;
  logic                 r_gpuDone;
  logic [NUM_REQ-1:0]   w_grant;
  logic                 w_inDraw;
  logic                 w_accept;
  logic [COORD_W-1:0]   w_selX;
  logic [COORD_W-1:0]   w_selY;
  logic [PIX_W-1:0]     w_selData;
  logic                 w_inRange;

`ifdef FRAME_WRITE_CLEAR_EN
  logic [COORD_W-1:0]   r_cx;
  logic [COORD_W-1:0]   r_cy;
  logic [PIX_W-1:0]     r_clearColor;
  logic                 w_firstPix;
  logic                 w_lastPix;
  logic [PIX_W-1:0]     w_clearData;

  // The colour is captured on the sweep's first pixel, which also uses it directly.
  assign w_firstPix  = (r_cx == '0) && (r_cy == '0);
  assign w_lastPix   = (r_cx == H_LIM - 1'b1) && (r_cy == V_LIM - 1'b1);
  assign w_clearData = w_firstPix ? clear_color : r_clearColor;
`else
  logic                 w_unusedClear;
  assign w_unusedClear = ^clear_color;
`endif

  assign w_rise    = gpu_start & ~r_startQ;
  assign w_inDraw  = (r_state == DRAW);
  assign w_accept  = w_inDraw & (|req_valid);
  assign req_ready = w_inDraw ? w_grant : '0;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (gpu_clk_150),
    .reset   (reset),
    .req     (req_valid),
    .advance (w_accept),
    .grant   (w_grant)
  );

  always_comb begin
    w_selX    = '0;
    w_selY    = '0;
    w_selData = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_selX    = req_x[i*COORD_W +: COORD_W];
        w_selY    = req_y[i*COORD_W +: COORD_W];
        w_selData = req_data[i*PIX_W +: PIX_W];
      end
    end
  end

  assign w_inRange = (w_selX < H_LIM) && (w_selY < V_LIM);

  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef FRAME_WRITE_CLEAR_EN
      CLEAR:   if (w_lastPix) w_next = DRAW;
`endif
      DRAW:    if ((&req_frame_done) && !(|req_valid)) w_next = DONE;
      DONE:    if (w_rise) w_next = START_PHASE;
      default: w_next = START_PHASE;
    endcase
  end

  always_ff @(posedge gpu_clk_150) begin
    if (reset) begin
      r_state      <= START_PHASE;
      r_startQ     <= 1'b0;
      r_gpuX       <= '0;
      r_gpuY       <= '0;
      r_gpuData    <= '0;
      r_gpuWe      <= 1'b0;
      r_gpuDone    <= 1'b0;
`ifdef FRAME_WRITE_CLEAR_EN
      r_cx         <= '0;
      r_cy         <= '0;
      r_clearColor <= '0;
`endif
    end else begin
      r_state   <= w_next;
      r_startQ  <= gpu_start;
      r_gpuDone <= (w_next == DONE);
      r_gpuWe   <= 1'b0;
      case (r_state)
`ifdef FRAME_WRITE_CLEAR_EN
        CLEAR: begin
          r_gpuX    <= r_cx;
          r_gpuY    <= r_cy;
          r_gpuData <= w_clearData;
          r_gpuWe   <= 1'b1;
          if (w_firstPix) r_clearColor <= clear_color;
          if (r_cx == H_LIM - 1'b1) begin
            r_cx <= '0;
            r_cy <= (r_cy == V_LIM - 1'b1) ? '0 : r_cy + 1'b1;
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
`endif
        DRAW: begin
          // Out-of-range requests are consumed but never written.
          if (w_accept) begin
            r_gpuX    <= w_selX;
            r_gpuY    <= w_selY;
            r_gpuData <= w_selData;
            r_gpuWe   <= w_inRange;
          end
        end
        default: ;
      endcase
    end
  end

  assign gpu_x    = r_gpuX;
  assign gpu_y    = r_gpuY;
  assign gpu_data = r_gpuData;
  assign gpu_we   = r_gpuWe;
  assign gpu_done = r_gpuDone;
  assign phase    = r_state;

endmodule

// File: tb/tb_frame_write_arbiter.sv
// Self-checking bench for frame_write_arbiter: directed scenarios plus random traffic against a frame-level model.
// Follows FRAME_WRITE_CLEAR_EN the same way the design does.
module tb_frame_write_arbiter;

  localparam int N = 2;
  localparam int H = 4;
  localparam int V = 2;
`ifdef FRAME_WRITE_CLEAR_EN
  localparam int RESTART_MODE = 0;
`else
  localparam int RESTART_MODE = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        gpu_start;
  logic [3:0]  clear_color;
  logic [1:0]  req_valid;
  logic [19:0] req_x;
  logic [19:0] req_y;
  logic [7:0]  req_data;
  logic [1:0]  req_ready;
  logic [1:0]  req_frame_done;
  logic [9:0]  gpu_x;
  logic [9:0]  gpu_y;
  logic [3:0]  gpu_data;
  logic        gpu_we;
  logic        gpu_done;
  logic [1:0]  phase;

  int total = 0;
  int bad   = 0;

  // Model state: mode 0=clear 1=draw 2=done; clear progress as a linear pixel index.
  bit   mValid = 0;
  int   mMode;
  int   mPix;
  int   mLast;
  int   mClr;
  bit   mStartQ;
  int   expX, expY, expData;
  bit   expWe, expDone;

  always #5 clk = ~clk;

  frame_write_arbiter #(.NUM_REQ(N), .H_RES(H), .V_RES(V)) dut (
    .gpu_clk_150    (clk),
    .reset          (reset),
    .gpu_start      (gpu_start),
    .clear_color    (clear_color),
    .req_valid      (req_valid),
    .req_x          (req_x),
    .req_y          (req_y),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .req_frame_done (req_frame_done),
    .gpu_x          (gpu_x),
    .gpu_y          (gpu_y),
    .gpu_data       (gpu_data),
    .gpu_we         (gpu_we),
    .gpu_done       (gpu_done),
    .phase          (phase)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input int x0, input int y0, input int x1, input int y1,
                               input logic [3:0] d0, input logic [3:0] d1, input logic [1:0] fd, input logic st);
    req_valid      = v;
    req_x          = {10'(x1), 10'(x0)};
    req_y          = {10'(y1), 10'(y0)};
    req_data       = {d1, d0};
    req_frame_done = fd;
    gpu_start      = st;
  endtask

  function automatic int modelGrant(input logic [1:0] v);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (mLast + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Frame-level reference: advances on each clock edge from the inputs seen at that edge.
  always @(posedge clk) begin
    if (reset) begin
      mValid  = 1;
      mMode   = RESTART_MODE;
      mPix    = 0;
      mLast   = N - 1;
      mClr    = 0;
      mStartQ = 0;
      expX = 0; expY = 0; expData = 0; expWe = 0; expDone = 0;
    end else if (mValid) begin
      bit rise;
      int g;
      rise    = gpu_start && !mStartQ;
      mStartQ = gpu_start;
      expWe   = 0;
      expDone = 0;
      if (mMode == 0) begin
        if (mPix == 0) mClr = int'(clear_color);
        expX    = mPix % H;
        expY    = mPix / H;
        expData = mClr;
        expWe   = 1;
        mPix++;
        if (mPix == H * V) begin
          mPix  = 0;
          mMode = 1;
        end
      end else if (mMode == 1) begin
        g = modelGrant(req_valid);
        if (g >= 0) begin
          expX    = int'(req_x[g*10 +: 10]);
          expY    = int'(req_y[g*10 +: 10]);
          expData = int'(req_data[g*4 +: 4]);
          expWe   = (expX < H) && (expY < V);
          mLast   = g;
        end else if (req_frame_done == 2'b11) begin
          mMode   = 2;
          expDone = 1;
        end
      end else begin
        if (rise) mMode = RESTART_MODE;
        else expDone = 1;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle when all outputs are settled.
  always @(negedge clk) begin
    if (mValid) begin
      int g;
      logic [31:0] expReady;
      g = modelGrant(req_valid);
      expReady = (mMode == 1 && g >= 0) ? (32'd1 << g) : 32'd0;
      checkOutput("phase", phase, mMode);
      checkOutput("gpu_we", gpu_we, expWe);
      checkOutput("gpu_done", gpu_done, expDone);
      checkOutput("req_ready", req_ready, expReady);
      if (expWe) begin
        checkOutput("gpu_x", gpu_x, expX);
        checkOutput("gpu_y", gpu_y, expY);
        checkOutput("gpu_data", gpu_data, expData);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    clear_color = 4'hA;
    applyStimulus(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_we", gpu_we, 0);
    checkOutput("rst_done", gpu_done, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_phase", phase, RESTART_MODE);
    #1 reset = 1'b0;

`ifdef FRAME_WRITE_CLEAR_EN
    for (int p = 0; p < 8; p++) begin
      @(posedge clk); #1;
      checkOutput("clr_we", gpu_we, 1);
      checkOutput("clr_x", gpu_x, p % 4);
      checkOutput("clr_y", gpu_y, p / 4);
      checkOutput("clr_data", gpu_data, 10);
    end
    checkOutput("clr_to_draw", phase, 1);
    #1;
`endif

    // Both requesters streaming: grants alternate starting from requester 0.
    applyStimulus(2'b11, 1, 0, 2, 1, 4'h3, 4'h5, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1 checkOutput("alt_ready", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      checkOutput("alt_we", gpu_we, 1);
      checkOutput("alt_x", gpu_x, (i % 2 == 0) ? 1 : 2);
      checkOutput("alt_y", gpu_y, (i % 2 == 0) ? 0 : 1);
      checkOutput("alt_data", gpu_data, (i % 2 == 0) ? 3 : 5);
      #1;
    end

    applyStimulus(2'b10, 0, 0, 400, 0, 4'h0, 4'h7, 2'b00, 1'b0);
    #1 checkOutput("oor_ready", req_ready, 2'b10);
    @(posedge clk); #1;
    checkOutput("oor_we", gpu_we, 0);
    #1;

    applyStimulus(2'b01, 3, 1, 0, 0, 4'h9, 4'h0, 2'b11, 1'b1);
    #1 checkOutput("last_ready", req_ready, 2'b01);
    @(posedge clk); #1;
    checkOutput("last_we", gpu_we, 1);
    checkOutput("last_x", gpu_x, 3);
    checkOutput("last_phase", phase, 1);
    #1 applyStimulus(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b11, 1'b1);
    @(posedge clk); #1;
    checkOutput("done_phase", phase, 2);
    checkOutput("done_flag", gpu_done, 1);
    checkOutput("done_we", gpu_we, 0);
    repeat (3) @(posedge clk);
    #1 checkOutput("held_start_done", gpu_done, 1);
    #1 gpu_start = 1'b0;
    @(posedge clk); #1;
    checkOutput("low_start_done", gpu_done, 1);
    #1 gpu_start = 1'b1;
    @(posedge clk); #1;
    checkOutput("restart_done", gpu_done, 0);
    checkOutput("restart_phase", phase, RESTART_MODE);
    #1 req_frame_done = 2'b00;

`ifdef FRAME_WRITE_CLEAR_EN
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midclr_we", gpu_we, 0);
    checkOutput("midclr_phase", phase, 0);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("reclr_we", gpu_we, 1);
    checkOutput("reclr_x", gpu_x, 0);
    checkOutput("reclr_y", gpu_y, 0);
    #1;
`else
    applyStimulus(2'b11, 1, 1, 2, 0, 4'h4, 4'h6, 2'b00, 1'b1);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("middraw_we", gpu_we, 0);
    checkOutput("middraw_done", gpu_done, 0);
    #1 reset = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 2'b00, 1'b1);
`endif

    // Random traffic: mixed ranges, sparse frame completions, start toggles and rare resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      applyStimulus(($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                    $urandom_range(0, 5), $urandom_range(0, 2),
                    $urandom_range(0, 5), $urandom_range(0, 2),
                    4'($urandom), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 7) == 0) ? ~gpu_start : gpu_start);
      clear_color = 4'($urandom);
      reset = ($urandom_range(0, 399) == 0);
    end

    @(posedge clk); #2;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
